// File: rtl/axis_uart_tx_arb.sv
// axis_uart_tx_arb: two-port packet-granular AXIS arbiter feeding a UART transmitter.
// Define GJ_TX_ARB_PRIO_EN for fixed port-0 priority; round-robin otherwise.
module axis_uart_tx_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] maxBytesPerFrame,
    input  logic [15:0] minTxGap,
    input  logic        clk_en,
    input  logic        s0_tvalid,
    input  logic [7:0]  s0_tdata,
    input  logic        s0_tlast,
    output logic        s0_tready,
    input  logic        s1_tvalid,
    input  logic [7:0]  s1_tdata,
    input  logic        s1_tlast,
    output logic        s1_tready,
    output logic        tx_tvalid,
    output logic [7:0]  tx_tdata,
    input  logic        tx_tready,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        overLen
);
    typedef enum logic [1:0] {IDLE, SEND, DROP, GAP} state_t;
    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] cnt_q, cnt_d, gap_q, gap_d;
    logic        pri_q, pri_d;
    logic        sel, sv, sl, win1;
    logic [7:0]  sd;
    logic [15:0] cnt_inc;
    assign sel     = grant_q[1];
    assign sv      = sel ? s1_tvalid : s0_tvalid;
    assign sd      = sel ? s1_tdata : s0_tdata;
    assign sl      = sel ? s1_tlast : s0_tlast;
    assign cnt_inc = cnt_q + 16'd1;
    assign grant   = grant_q;
    assign busy    = state_q != IDLE;
`ifdef GJ_TX_ARB_PRIO_EN
    assign win1 = !s0_tvalid;
`else
    // pri_q set means port 1 is favoured on a simultaneous request
    assign win1 = s1_tvalid & (!s0_tvalid | pri_q);
`endif
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        pri_d     = pri_q;
        tx_tvalid = 1'b0;
        tx_tdata  = 8'd0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        overLen   = 1'b0;
        case (state_q)
            IDLE: if (s0_tvalid | s1_tvalid) begin
                grant_d = win1 ? 2'b10 : 2'b01;
                cnt_d   = 16'd0;
                state_d = SEND;
            end
            SEND: begin
                tx_tvalid              = sv;
                tx_tdata               = sd;
                {s1_tready, s0_tready} = grant_q & {2{tx_tready}};
                if (sv & tx_tready) begin
                    cnt_d = cnt_inc;
                    if (sl) begin
                        state_d = GAP;
                        gap_d   = minTxGap;
                        pri_d   = ~sel;
                    end else if (maxBytesPerFrame != 16'd0 && cnt_inc == maxBytesPerFrame) begin
                        overLen = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                {s1_tready, s0_tready} = grant_q;
                if (sv & sl) begin
                    state_d = GAP;
                    gap_d   = minTxGap;
                    pri_d   = ~sel;
                end
            end
            GAP: if (gap_q == 16'd0) begin
                state_d = IDLE;
                grant_d = 2'b00;
            end else if (clk_en) begin
                gap_d = gap_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            cnt_q   <= 16'd0;
            gap_q   <= 16'd0;
            pri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pri_q   <= pri_d;
        end
    end
endmodule
